// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one 64-bit logical shifter between the
// execute-stage requester (0) and the load/store byte-align requester (1).

module shift_core #(
  parameter int DATA_W = 64,
  parameter int DIST_W = 6
) (
  input  logic [DATA_W-1:0] i_value,
  input  logic              i_dir,
  input  logic [DIST_W-1:0] i_dist,
  output logic [DATA_W-1:0] o_value
);

  // Log shifter: stage k moves the operand by 2**k when dist bit k is set.
  logic [DATA_W-1:0] w_stage [0:DIST_W];

  assign w_stage[0] = i_value;

  for (genvar k = 0; k < DIST_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    logic [DATA_W-1:0] w_moved;

    assign w_moved        = i_dir ? (w_stage[k] >> SH) : (w_stage[k] << SH);
    assign w_stage[k + 1] = i_dist[k] ? w_moved : w_stage[k];
  end

  assign o_value = w_stage[DIST_W];

endmodule

module shift_arbiter #(
  parameter int DATA_W = 64,
  parameter int DIST_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_value,
  input  logic              req0_dir,
  input  logic [DIST_W-1:0] req0_dist,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_value,
  input  logic              req1_dir,
  input  logic [DIST_W-1:0] req1_dist,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_run;
  logic              r_rr_ptr;
  logic              r_res_id;
  logic [DATA_W-1:0] r_res_data;

  logic              w_res_valid;
  logic              w_can_accept;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_grant_any;
  logic [DATA_W-1:0] w_op_value;
  logic              w_op_dir;
  logic [DIST_W-1:0] w_op_dist;
  logic [DATA_W-1:0] w_shifted;

  // Goes high at the first edge that sees rst_n released, so nothing
  // handshakes in the partial cycle right after reset deasserts.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_grant_any) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_grant_any)    w_state_nxt = S_FULL;
        else if (res_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    w_res_valid  = (r_state == S_FULL);
    w_can_accept = r_run & (~w_res_valid | res_ready);
  end

  // Contention goes to the requester named by r_rr_ptr; a lone request
  // always wins, whatever the pointer says.
  always_comb begin
    w_grant0    = w_can_accept & req0_valid & (~req1_valid | ~r_rr_ptr);
    w_grant1    = w_can_accept & req1_valid & (~req0_valid |  r_rr_ptr);
    w_grant_any = w_grant0 | w_grant1;
  end

  // Payload of a requester without a grant never reaches the shifter.
  always_comb begin
    w_op_value = '0;
    w_op_dir   = 1'b0;
    w_op_dist  = '0;
    if (w_grant0) begin
      w_op_value = req0_value;
      w_op_dir   = req0_dir;
      w_op_dist  = req0_dist;
    end else if (w_grant1) begin
      w_op_value = req1_value;
      w_op_dir   = req1_dir;
      w_op_dist  = req1_dist;
    end
  end

  shift_core #(
    .DATA_W (DATA_W),
    .DIST_W (DIST_W)
  ) u_shift_core (
    .i_value (w_op_value),
    .i_dir   (w_op_dir),
    .i_dist  (w_op_dist),
    .o_value (w_shifted)
  );

  // Result register doubles as the operand stage: a grant overwrites it
  // even while a drain happens on the same edge, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data <= '0;
      r_res_id   <= 1'b0;
      r_rr_ptr   <= 1'b0;
    end else if (w_grant_any) begin
      r_res_data <= w_shifted;
      r_res_id   <= w_grant1;
      r_rr_ptr   <= w_grant0;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign res_valid  = w_res_valid;
  assign res_data   = r_res_data;
  assign res_id     = r_res_id;

endmodule
